fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that supplies 16-bit instruction words to the opcode decoder. It owns the PC and issues one-outstanding word requests to instruction memory over a req/gnt/rvalid handshake. Returned words are buffered in a small queue and presented to decode with a valid/ready handshake. The block handles branch redirects from execute, including flush and discard of in-flight responses, and stops fetching after a HLT opcode.

## Interface
- DEPTH, 2, instruction queue entries (power of 2, ≥2)
- RESET_PC, 16'h0000, PC value after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- mem_req  out  1  fetch request; held with mem_addr until mem_gnt
- mem_addr  out  16  byte address of requested word
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid; ≥1 cycle after gnt, in order
- mem_rdata  in  16  instruction word
- redirect  in  1  taken branch/Br: flush and restart at redirect_pc
- redirect_pc  in  16  new PC (bit 0 ignored, forced 0)
- inst_valid  out  1  queue head valid
- inst  out  16  queue head word
- inst_pc  out  16  address of inst
- inst_pcinc  out  16  inst_pc + 2 (for PCS)
- inst_ready  in  1  decode accepts head
- halted  out  1  sticky: HLT accepted by decode

## Operation
- FSM states: IDLE, REQ, WAIT. Flags: stop (HLT fetched), discard (drop next response).
- IDLE → REQ when !stop, !redirect, queue count < DEPTH; req_addr ← pc.
- REQ: mem_req=1, mem_addr=req_addr, both stable until mem_gnt; → WAIT on gnt (same-cycle gnt allowed).
- WAIT: on mem_rvalid → IDLE. If !discard and !redirect: push {mem_rdata, req_addr}, pc ← req_addr+2 (16-bit wrap, FFFE→0000). discard ← 0.
- Pushed word with [15:12]=4'hF sets stop; no further requests.
- redirect (any state): queue flushed, pc ← redirect_pc, stop ← 0. In REQ or WAIT, the request is not withdrawn; discard ← 1 and its response is dropped. In WAIT with mem_rvalid in the same cycle, the response is dropped and discard stays 0.
- Decode handshake: pop when inst_valid & inst_ready & !redirect. A handshake coinciding with redirect is void (word squashed).
- halted ← 1 on a valid pop of a word with opcode 4'hF; cleared only by reset.
- At most one request outstanding (REQ or WAIT). Space check uses count before the current cycle's pop.

## Timing
- Reset (rst_n sampled low): pc=RESET_PC, state IDLE, mem_req=0, mem_addr=RESET_PC, queue empty, inst_valid=0, inst=0, inst_pc=0, inst_pcinc=2, halted=0, stop=0, discard=0. Reset mid-transaction abandons it. The memory model must drop any late rvalid after reset.
- First mem_req: second cycle after rst_n high (IDLE→REQ registered).
- rvalid in cycle N → inst_valid in N+1 (queue registered, no bypass).
- Peak throughput: 1 word/3 cycles (IDLE, REQ+gnt, WAIT+rvalid).
- Queue full: no new request; existing WAIT response always has a slot (credit rule).
- Redirect in cycle N: inst_valid=0 in N+1; earliest mem_req for redirect_pc in N+2 if IDLE, else after the discarded response.

## Structure
- Shared package fetch_pkg: INST_W=16, OP_HLT=4'hF, PC_INC=16'd2, fetch state enum {IDLE, REQ, WAIT}.
- Sub-module inst_fifo: DEPTH×32 {word, pc}, push/pop/flush, count, full/empty; flush dominates push and pop.
- Top holds FSM, pc/req_addr, stop/discard/halted.

## Test plan
- Reset, mem gnt immediate, rvalid 1 cycle later, mem[0]=16'h1234, mem[2]=16'h2345 → inst 1234@pc 0000 (pcinc 0002), then 2345@0002; first mem_req 2 cycles after reset release.
- inst_ready=0 → exactly DEPTH=2 words queued, mem_req stays 0; ready=1 → words pop in order, fetch resumes at 0004.
- redirect to 0040 while in WAIT for 0006 → 0006 response dropped, next mem_addr=0040, inst_valid=0 until 0040's word arrives.
- mem[4]=16'hF000 → no request for 0006; halted=1 the cycle after F000 is accepted; no further mem_req.
- redirect, mem_rvalid and inst_valid&inst_ready all in one cycle → response dropped, pop void, halted unchanged, next fetch at redirect_pc.
- rst_n low while mem_req=1 with gnt withheld → next cycle mem_req=0, mem_addr=RESET_PC, queue empty, halted=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch stage.
//   INST_W        instruction / address width
//   OP_HLT        opcode (bits [15:12]) that stops fetching
//   PC_INC        byte distance between consecutive instruction words
//   fetch_state_t memory-request FSM states
//   fetch_entry_t one instruction-queue entry {word, pc}
package fetch_pkg;

  localparam int unsigned INST_W = 16;
  localparam logic [3:0]  OP_HLT = 4'hF;
  localparam logic [15:0] PC_INC = 16'd2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] word;
    logic [INST_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic is_hlt(input logic [INST_W-1:0] w);
    return w[INST_W-1 -: 4] == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_unit_inst_fifo.sv
// inst_fifo: DEPTH-entry queue of {word, pc} between memory and decode.
//   clk, rst_n  clock, synchronous active-low reset
//   flush       empty the queue; dominates push and pop
//   push        write push_data at the tail
//   pop         retire the head entry
//   head        current head entry (meaningful only when count != 0)
//   count       number of valid entries
//   full        count == DEPTH
module inst_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the top gates the head with count != 0.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= push_data;
  end

  assign head = mem[rptr];
  assign full = (count == FULL_CNT);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the opcode decoder.
//   clk, rst_n                         clock, synchronous active-low reset
//   mem_req/mem_addr/mem_gnt           one-outstanding request to instruction memory
//   mem_rvalid/mem_rdata               in-order read response
//   redirect/redirect_pc               taken branch: flush queue, restart at redirect_pc
//   inst_valid/inst/inst_pc/inst_pcinc queue head presented to decode
//   inst_ready                         decode accepts the head
//   halted                             sticky: HLT accepted by decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned  DEPTH    = 2,
  parameter logic [15:0]  RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [INST_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [INST_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [INST_W-1:0] inst_pc,
  output logic [INST_W-1:0] inst_pcinc,
  input  logic              inst_ready,
  output logic              halted
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  logic [INST_W-1:0] pc;
  logic [INST_W-1:0] req_addr;
  logic              stop;
  logic              discard;

  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic [CW-1:0]     q_count;
  fetch_entry_t      q_head;
  fetch_entry_t      q_in;

  assign inst_valid = (q_count != '0);
  // A handshake in the same cycle as a redirect is squashed with the flush.
  assign q_pop      = inst_valid && inst_ready && !redirect;
  assign q_push     = (state == WAIT) && mem_rvalid && !discard && !redirect;
  assign q_in       = '{word: mem_rdata, pc: req_addr};

  assign inst       = inst_valid ? q_head.word : '0;
  assign inst_pc    = inst_valid ? q_head.pc   : '0;
  assign inst_pcinc = inst_pc + PC_INC;
  assign mem_addr   = req_addr;

  inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      mem_req  <= 1'b0;
      stop     <= 1'b0;
      discard  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      if (q_pop && is_hlt(q_head.word)) halted <= 1'b1;

      case (state)
        IDLE: begin
          // Only one request in flight, so a free slot now is still free
          // when its response returns.
          if (!stop && !redirect && !q_full) begin
            state    <= REQ;
            req_addr <= pc;
            mem_req  <= 1'b1;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state   <= WAIT;
            mem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state   <= IDLE;
            discard <= 1'b0;
            if (!discard && !redirect) begin
              pc <= req_addr + PC_INC;
              if (is_hlt(mem_rdata)) stop <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase

      // The request in flight is never withdrawn; its response is dropped
      // instead. A response arriving with the redirect is dropped directly.
      if (redirect) begin
        pc   <= {redirect_pc[INST_W-1:1], 1'b0};
        stop <= 1'b0;
        if ((state == REQ) || ((state == WAIT) && !mem_rvalid)) discard <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [15:0] mem_addr, mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        inst_valid, inst_ready, halted;
  logic [15:0] inst, inst_pc, inst_pcinc;

  int n_vec = 0;
  int n_bad = 0;
  int n_pop = 0;

  logic [15:0] imem [128];
  logic        gnt_en;
  int          lat;

  logic [15:0] exp_addr [$];
  logic [31:0] exp_inst [$];

  fetch_unit #(
    .DEPTH    (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_pcinc  (inst_pcinc),
    .inst_ready  (inst_ready),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_stream(input logic [15:0] start, input int n);
    logic [15:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(a);
      exp_inst.push_back({imem[a[7:1]], a});
      a = a + 16'd2;
    end
  endtask

  task automatic flush_expect();
    exp_addr.delete();
    exp_inst.delete();
  endtask

  // Memory: inputs change at negedge, grant in cycle c -> rvalid in c+lat.
  initial begin : memmodel
    logic        pend;
    int          cnt;
    logic [15:0] paddr;
    pend = 1'b0; cnt = 0; paddr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = imem[paddr[7:1]];
            pend       = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (!pend && !mem_rvalid && mem_req && gnt_en) begin
          mem_gnt = 1'b1;
          pend    = 1'b1;
          cnt     = lat - 1;
          paddr   = mem_addr;
        end
      end
    end
  end

  // Scoreboard: granted addresses and decode handshakes against expectations.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (mem_req && mem_gnt) begin
          chk("req_expected", 48'(exp_addr.size() != 0), 48'd1);
          if (exp_addr.size() != 0)
            chk("req_addr", 48'(mem_addr), 48'(exp_addr.pop_front()));
        end
        if (inst_valid && inst_ready && !redirect) begin
          n_pop++;
          chk("pop_expected", 48'(exp_inst.size() != 0), 48'd1);
          if (exp_inst.size() != 0) begin
            e = exp_inst.pop_front();
            chk("inst", {inst, inst_pc, inst_pcinc}, {e, e[15:0] + 16'd2});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #60000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    for (int i = 0; i < 128; i++) imem[i] = 16'h1000 + 16'(i);
    imem[0]  = 16'h1234; imem[1]  = 16'h2345; imem[2]  = 16'h3456; imem[3]  = 16'h4567;
    imem[32] = 16'h5678; imem[33] = 16'h6789; imem[34] = 16'h789A; imem[35] = 16'h89AB;
    rst_n = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    gnt_en = 1'b1; lat = 1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", 48'(mem_req), 48'd0);
    chk("rst_mem_addr", 48'(mem_addr), 48'h0000);
    chk("rst_inst_valid", 48'(inst_valid), 48'd0);
    chk("rst_inst", {inst, inst_pc, inst_pcinc}, {16'h0, 16'h0, 16'h2});
    chk("rst_halted", 48'(halted), 48'd0);

    // Fill with decode stalled: two words queued, then no request
    expect_stream(16'h0000, 2);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("first_req", 48'(mem_req), 48'd1);
    chk("first_addr", 48'(mem_addr), 48'h0000);
    k = 0;
    while (!mem_rvalid && k < 20) begin @(negedge clk); #1; k++; end
    chk("rvalid0_seen", 48'(mem_rvalid), 48'd1);
    @(negedge clk); #1;
    chk("lat_valid", 48'(inst_valid), 48'd1);
    chk("lat_inst", {inst, inst_pc, inst_pcinc}, {16'h1234, 16'h0000, 16'h0002});
    repeat (15) @(negedge clk);
    #1;
    chk("full_noreq", 48'(mem_req), 48'd0);
    chk("full_head", {inst_valid, inst}, {31'd0, 1'b1, 16'h1234});

    // Drain and resume at 0004; redirect while waiting for 0006
    lat = 3;
    expect_stream(16'h0004, 2);
    inst_ready = 1'b1;
    k = 0;
    while (!(mem_req && mem_gnt && mem_addr == 16'h0006) && k < 80) begin @(negedge clk); #1; k++; end
    chk("grant6_seen", 48'(mem_req && mem_gnt && mem_addr == 16'h0006), 48'd1);
    @(negedge clk); #1;
    redirect = 1'b1; redirect_pc = 16'h0041;
    flush_expect();
    expect_stream(16'h0040, 6);
    @(negedge clk); #1;
    redirect = 1'b0;
    chk("redir_flush", 48'(inst_valid), 48'd0);
    k = 0;
    while (!mem_rvalid && k < 20) begin @(negedge clk); #1; k++; end
    chk("rvalid6_seen", 48'(mem_rvalid), 48'd1);
    @(negedge clk); #1;
    chk("discard_drop", 48'(inst_valid), 48'd0);
    k = n_pop;
    for (int w = 0; w < 40 && n_pop == k; w++) begin @(negedge clk); #1; end
    chk("pop40_seen", 48'(n_pop - k), 48'd1);

    // Redirect, rvalid and a decode handshake all in one cycle
    inst_ready = 1'b0;
    imem[2] = 16'hF000;
    k = 0;
    while (!(mem_rvalid && inst_valid) && k < 60) begin @(negedge clk); #1; k++; end
    chk("combo_seen", 48'(mem_rvalid && inst_valid), 48'd1);
    redirect = 1'b1; redirect_pc = 16'h0000; inst_ready = 1'b1;
    flush_expect();
    expect_stream(16'h0000, 3);
    @(negedge clk); #1;
    redirect = 1'b0;
    chk("combo_flush", 48'(inst_valid), 48'd0);
    chk("combo_halted", 48'(halted), 48'd0);

    // HLT at 0004: no fetch of 0006, halted after acceptance
    k = 0;
    while (!(inst_valid && inst == 16'hF000) && k < 60) begin @(negedge clk); #1; k++; end
    chk("hlt_seen", 48'(inst_valid && inst == 16'hF000), 48'd1);
    chk("hlt_pre", 48'(halted), 48'd0);
    @(negedge clk); #1;
    chk("hlt_set", 48'(halted), 48'd1);
    repeat (20) @(negedge clk);
    #1;
    chk("hlt_noreq", 48'(mem_req), 48'd0);
    chk("hlt_empty", 48'(inst_valid), 48'd0);

    // Reset while a request is held without grant
    lat = 1; inst_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0000;
    flush_expect();
    expect_stream(16'h0000, 2);
    @(negedge clk); #1;
    redirect = 1'b0;
    k = 0;
    while (!inst_valid && k < 20) begin @(negedge clk); #1; k++; end
    chk("pre_rst_valid", 48'(inst_valid), 48'd1);
    gnt_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("hold_req", {mem_req, mem_addr}, {31'd0, 1'b1, 16'h0002});
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_req", {mem_req, mem_addr}, {31'd0, 1'b0, 16'h0000});
    chk("mid_rst_queue", {inst_valid, inst}, 48'd0);
    chk("mid_rst_halted", 48'(halted), 48'd0);
    flush_expect();

    // Restart after reset runs through to the HLT again
    repeat (2) @(negedge clk);
    #1;
    gnt_en = 1'b1; inst_ready = 1'b1;
    expect_stream(16'h0000, 3);
    rst_n = 1'b1;
    k = n_pop;
    for (int w = 0; w < 60 && n_pop < k + 3; w++) begin @(negedge clk); #1; end
    chk("rerun_pops", 48'(n_pop - k), 48'd3);
    chk("rerun_halted", 48'(halted), 48'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
